// File: rtl/load_store_unit_if.sv
// Request/response and word-memory signals of the load/store unit.
// The LSU sits on the slave side; the requester and the memory sit on the master side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory with a registered 1-cycle read.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; faults are answered directly from here
// RD    | mem_re asserted on the latched word address
// LD    | mem_rdata valid: extract lane, extend, register the response
// MERGE | mem_rdata valid: splice SB/SH data into the word, write back
// WR    | full-word store, written straight from wdata_q
module load_store_unit #(
   parameter logic [31:0] ADDR_LIMIT  = 32'h0000_1000,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_LD    = 3'd2,
      S_MERGE = 3'd3,
      S_WR    = 3'd4
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic        write_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic        accept;
   logic        is_half;
   logic        is_word;
   logic        misaligned;
   logic        bad_funct3;
   logic        out_of_range;
   logic        req_fault;
   logic [31:0] addr_in;

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   // ---------------------------------------------------------------
   // Request qualification
   // ---------------------------------------------------------------
   assign accept  = bus.req_valid && (state_q == S_IDLE);
   assign is_half = (bus.req_funct3[1:0] == 2'b01);
   assign is_word = (bus.req_funct3[1:0] == 2'b10);

   always_comb begin
      misaligned   = (is_half && bus.req_addr[0]) ||
                     (is_word && (bus.req_addr[1:0] != 2'b00));
      out_of_range = (bus.req_addr >= ADDR_LIMIT);
      if (bus.req_write) begin
         bad_funct3 = (bus.req_funct3 >= 3'b011);
      end else begin
         bad_funct3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
      end
      req_fault = out_of_range || bad_funct3 || (ALIGN_CHECK && misaligned);
   end

   // Without alignment checking, misaligned low bits are simply dropped.
   always_comb begin
      addr_in = bus.req_addr;
      if (!ALIGN_CHECK) begin
         if (is_word) addr_in[1:0] = 2'b00;
         if (is_half) addr_in[0]   = 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && !req_fault) begin
               if (bus.req_write && (bus.req_funct3 == 3'b010)) state_d = S_WR;
               else                                             state_d = S_RD;
            end
         end
         S_RD:    state_d = write_q ? S_MERGE : S_LD;
         S_LD:    state_d = S_IDLE;
         S_MERGE: state_d = S_IDLE;
         S_WR:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Lane extraction and merge
   // ---------------------------------------------------------------
   always_comb begin
      rd_byte = 8'h00;
      case (addr_q[1:0])
         2'b00: rd_byte = bus.mem_rdata[7:0];
         2'b01: rd_byte = bus.mem_rdata[15:8];
         2'b10: rd_byte = bus.mem_rdata[23:16];
         2'b11: rd_byte = bus.mem_rdata[31:24];
         default: rd_byte = 8'h00;
      endcase
      rd_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

      load_data = bus.mem_rdata;
      case (funct3_q)
         3'b000: load_data = {{24{rd_byte[7]}}, rd_byte};
         3'b001: load_data = {{16{rd_half[15]}}, rd_half};
         3'b100: load_data = {24'h00_0000, rd_byte};
         3'b101: load_data = {16'h0000, rd_half};
         default: load_data = bus.mem_rdata;
      endcase
   end

   always_comb begin
      merge_data = bus.mem_rdata;
      if (funct3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'b00: merge_data[7:0]   = wdata_q[7:0];
            2'b01: merge_data[15:8]  = wdata_q[7:0];
            2'b10: merge_data[23:16] = wdata_q[7:0];
            2'b11: merge_data[31:24] = wdata_q[7:0];
            default: merge_data = bus.mem_rdata;
         endcase
      end else begin
         if (addr_q[1]) merge_data[31:16] = wdata_q[15:0];
         else           merge_data[15:0]  = wdata_q[15:0];
      end
   end

   // ---------------------------------------------------------------
   // Request latch and registered response
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         write_q      <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         if (accept) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= addr_in;
            wdata_q  <= bus.req_wdata;
            if (req_fault) begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b1;
            end
         end
         case (state_q)
            S_LD: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= load_data;
            end
            S_MERGE, S_WR: resp_valid_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Outputs: strobes decoded from state, so we and re are exclusive
   // ---------------------------------------------------------------
   always_comb begin
      bus.req_ready  = (state_q == S_IDLE);
      bus.resp_valid = resp_valid_q;
      bus.resp_err   = resp_err_q;
      bus.resp_rdata = resp_rdata_q;
      bus.mem_addr   = {addr_q[31:2], 2'b00};
      bus.mem_re     = (state_q == S_RD);
      bus.mem_we     = (state_q == S_MERGE) || (state_q == S_WR);
      bus.mem_wdata  = 32'h0000_0000;
      if (state_q == S_MERGE) bus.mem_wdata = merge_data;
      else if (state_q == S_WR) bus.mem_wdata = wdata_q;
   end

endmodule
